// File: rtl/md5_candidate_generator.sv
// Brute-force candidate generator: walks every string of min..max characters up to MAX_LEN long
// and presents each one as a padded single-block MD5 message.
module md5_candidate_generator #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic [7:0]   min_i,
  input  logic [7:0]   max_i,
  output logic [511:0] chunk_o,
  output logic         valid_o,
  output logic [3:0]   length_o,
  output logic         exhausted_o,
  output logic         range_error_o,
  output logic [63:0]  count_o
);

  localparam logic [3:0] MaxLen = 4'(MAX_LEN);

  typedef enum logic [1:0] {StRun, StDone, StError} state_e;

  state_e         state_q, state_d;
  logic [7:0]     min_q, max_q;
  logic [7:0]     chars_q [MAX_LEN];
  logic [7:0]     chars_d [MAX_LEN];
  logic [3:0]     len_q, len_d;
  logic [63:0]    count_q, count_d;
  logic [511:0]   chunk_q, chunk_d;
  logic           valid_q, exhausted_q, range_error_q;
  logic           consume;
  logic           carry;

  assign consume = enable_i & valid_q & ~reset_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    chars_d = chars_q;
    carry   = 1'b0;
    if (reset_i) begin
      // Reset uses the live inputs: they are captured on this same edge.
      for (int i = 0; i < int'(MAX_LEN); i++) chars_d[i] = min_i;
      len_d   = 4'd1;
      count_d = '0;
      state_d = (min_i > max_i) ? StError : StRun;
    end else if (consume) begin
      count_d = count_q + 64'd1;
      carry   = 1'b1;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (carry && (4'(i) < len_q)) begin
          if (chars_q[i] < max_q) begin
            chars_d[i] = chars_q[i] + 8'd1;
            carry      = 1'b0;
          end else begin
            chars_d[i] = min_q;
          end
        end
      end
      if (carry) begin
        if (len_q < MaxLen) begin
          len_d = len_q + 4'd1;
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (4'(i) == len_q) chars_d[i] = min_q;
          end
        end else begin
          // Keep the final all-max candidate visible in DONE.
          chars_d = chars_q;
          state_d = StDone;
        end
      end
    end
  end

  always_comb begin
    chunk_d = '0;
    if (state_d != StError) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (4'(i) < len_d) chunk_d[8*i +: 8] = chars_d[i];
      end
      for (int i = 0; i < 16; i++) begin
        if (4'(i) == len_d) chunk_d[8*i +: 8] = 8'h80;
      end
      chunk_d[511:448] = {57'd0, len_d, 3'd0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      min_q <= min_i;
      max_q <= max_i;
    end
    state_q       <= state_d;
    chars_q       <= chars_d;
    len_q         <= len_d;
    count_q       <= count_d;
    chunk_q       <= chunk_d;
    valid_q       <= ~reset_i && (state_d == StRun);
    exhausted_q   <= (state_d == StDone);
    range_error_q <= (state_d == StError);
  end

  assign chunk_o       = chunk_q;
  assign valid_o       = valid_q;
  assign length_o      = len_q;
  assign exhausted_o   = exhausted_q;
  assign range_error_o = range_error_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_md5_candidate_generator.sv
// Directed bench: two generator instances (MAX_LEN 8 and 2) share stimulus; each step checks
// hand-computed chunk/length/flag/count values.
module tb_md5_candidate_generator;

  logic         clk = 1'b0;
  logic         reset, enable;
  logic [7:0]   min_v, max_v;

  logic [511:0] chunk8, chunk2;
  logic         valid8, valid2, exh8, exh2, rerr8, rerr2;
  logic [3:0]   len8, len2;
  logic [63:0]  cnt8, cnt2;

  int tests = 0;
  int fails = 0;

  logic [511:0] exp_chunk;
  logic [15:0]  seq_lo [5];
  logic [3:0]   seq_len [5];

  always #5 clk = ~clk;

  md5_candidate_generator #(.MAX_LEN(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .min_i(min_v), .max_i(max_v),
    .chunk_o(chunk8), .valid_o(valid8), .length_o(len8), .exhausted_o(exh8),
    .range_error_o(rerr8), .count_o(cnt8)
  );

  md5_candidate_generator #(.MAX_LEN(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .min_i(min_v), .max_i(max_v),
    .chunk_o(chunk2), .valid_o(valid2), .length_o(len2), .exhausted_o(exh2),
    .range_error_o(rerr2), .count_o(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; min_v = 8'h61; max_v = 8'h7A;

    // Reset state: first candidate "a" already encoded, valid still low.
    exp_chunk = '0;
    exp_chunk[7:0] = 8'h61; exp_chunk[15:8] = 8'h80; exp_chunk[455:448] = 8'h08;
    tick();
    check("rst_valid", valid8, 0);
    check("rst_len", len8, 1);
    check("rst_count", cnt8, 0);
    check("rst_chunk", chunk8, exp_chunk);
    check("rst_rerr", rerr8, 0);
    check("rst_exh", exh8, 0);

    reset = 1'b0;
    tick();
    check("idle_valid", valid8, 1);
    check("idle_chunk", chunk8, exp_chunk);
    tick();
    check("idle_count", cnt8, 0);

    // Alternating enable; input changes after reset must be ignored.
    min_v = 8'h30; max_v = 8'h31;
    enable = 1'b1; tick();
    check("tog1_count", cnt8, 1);
    check("tog1_char", chunk8[15:0], 16'h8062);
    enable = 1'b0; tick();
    check("tog2_count", cnt8, 1);
    check("tog2_char", chunk8[15:0], 16'h8062);
    enable = 1'b1; tick();
    check("tog3_char", chunk8[15:0], 16'h8063);
    enable = 1'b0; tick();
    check("tog4_count", cnt8, 2);
    check("tog4_char", chunk8[15:0], 16'h8063);

    // 26 consumes roll over into length 2 ("aa").
    min_v = 8'h61; max_v = 8'h7A;
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    enable = 1'b1;
    repeat (26) tick();
    exp_chunk = '0;
    exp_chunk[15:0] = 16'h6161; exp_chunk[23:16] = 8'h80; exp_chunk[455:448] = 8'h10;
    check("roll_len", len8, 2);
    check("roll_chunk", chunk8, exp_chunk);
    check("roll_count", cnt8, 26);

    // 100 consumes total: index 74 of length 2 -> char0 'w', char1 'c'.
    repeat (74) tick();
    check("c100_count", cnt8, 100);
    check("c100_chars", chunk8[23:0], 24'h806377);

    // Reset wins over enable, then restart from "a".
    reset = 1'b1; tick();
    check("mid_rst_count", cnt8, 0);
    check("mid_rst_len", len8, 1);
    check("mid_rst_valid", valid8, 0);
    check("mid_rst_char", chunk8[15:0], 16'h8061);
    reset = 1'b0; tick();
    check("post_rst_valid", valid8, 1);
    check("post_rst_count", cnt8, 0);
    check("post_rst_char", chunk8[15:0], 16'h8061);
    tick();
    check("post_rst_cons", cnt8, 1);

    // MAX_LEN=2, range a..b: a, b, aa, ba, ab, bb, then DONE.
    enable = 1'b0; min_v = 8'h61; max_v = 8'h62;
    seq_lo[0] = 16'h8062; seq_lo[1] = 16'h6161; seq_lo[2] = 16'h6162;
    seq_lo[3] = 16'h6261; seq_lo[4] = 16'h6262;
    seq_len[0] = 4'd1; seq_len[1] = 4'd2; seq_len[2] = 4'd2; seq_len[3] = 4'd2; seq_len[4] = 4'd2;
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    check("ab_first", chunk2[15:0], 16'h8061);
    check("ab_first_valid", valid2, 1);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ab_seq%0d_chars", k), chunk2[15:0], seq_lo[k]);
      check($sformatf("ab_seq%0d_len", k), len2, seq_len[k]);
    end
    tick();
    check("done_valid", valid2, 0);
    check("done_exh", exh2, 1);
    check("done_count", cnt2, 6);
    exp_chunk = '0;
    exp_chunk[15:0] = 16'h6262; exp_chunk[23:16] = 8'h80; exp_chunk[455:448] = 8'h10;
    check("done_chunk", chunk2, exp_chunk);
    tick();
    check("done_hold_count", cnt2, 6);
    check("done_hold_len", len2, 2);

    // min == max: one candidate per length.
    enable = 1'b0; max_v = 8'h61;
    reset = 1'b1; tick();
    check("eq_rst_exh", exh2, 0);
    reset = 1'b0; tick();
    enable = 1'b1; tick();
    check("eq_len2", chunk2[23:0], 24'h806161);
    tick();
    check("eq_exh", exh2, 1);
    check("eq_count", cnt2, 2);

    // min > max selects ERROR.
    enable = 1'b0; min_v = 8'h7A; max_v = 8'h61;
    reset = 1'b1; tick();
    reset = 1'b0; enable = 1'b1;
    repeat (3) tick();
    check("err_flag", rerr8, 1);
    check("err_valid", valid8, 0);
    check("err_chunk", chunk8, 0);
    check("err_count", cnt8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md5_candidate_generator.md
MD5_CANDIDATE_GENERATOR -- requirements
Module: md5_candidate_generator

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum candidate length in characters; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  consumer accepts the current candidate this cycle.
REQ-005 min  input  8  lowest character code, inclusive.
REQ-006 max  input  8  highest character code, inclusive.
REQ-007 chunk  output  512  current candidate as a padded single-block MD5 message.
REQ-008 valid  output  1  chunk holds an unconsumed legal candidate.
REQ-009 length  output  4  character count of the current candidate.
REQ-010 exhausted  output  1  every candidate up to MAX_LEN has been consumed.
REQ-011 rangeError  output  1  captured min > max.
REQ-012 count  output  64  number of candidates consumed since reset.

Function
REQ-013 Byte i of chunk SHALL be chunk[8i+7:8i]; bytes 0..length-1 hold characters, byte length holds 0x80, bytes length+1..55 hold 0, bytes 56..63 hold the 64-bit little-endian value length*8.
REQ-014 Character text SHALL occupy only chunk[127:0], since MAX_LEN <= 15 leaves byte 15 as the last possible 0x80 position.
REQ-015 States SHALL be RUN, DONE and ERROR, held in registers; valid = 1 only in RUN.
REQ-016 min and max SHALL be captured into internal registers only on cycles with reset high; later input changes SHALL be ignored until the next reset.
REQ-017 A consume SHALL occur on a cycle with enable = 1 and valid = 1; count increments by 1 (wrap at 2^64).
REQ-018 On consume, character 0 is least significant: if char0 < max it increments by 1, otherwise it becomes min and the carry propagates to char1, and so on up to char length-1.
REQ-019 If the carry leaves char length-1 and length < MAX_LEN, length SHALL increment and all characters up to the new length SHALL be min.
REQ-020 If the carry leaves char length-1 and length = MAX_LEN, the state SHALL move to DONE.
REQ-021 In DONE, chunk and length SHALL keep the final candidate (all max, length MAX_LEN), with exhausted = 1 and valid = 0.
REQ-022 chunk, length and valid SHALL be registered outputs that update on the clock edge following a consume; consume-to-next-candidate latency is 1 cycle, giving one candidate per cycle under continuous enable.
REQ-023 enable = 0 SHALL hold all state and outputs unchanged.
REQ-024 min = max SHALL yield exactly one candidate per length.
REQ-025 Captured min > max SHALL select ERROR: rangeError = 1, valid = 0, chunk = 0, and no consumes occur.
REQ-026 Candidates SHALL be produced in this order, without repeats or gaps: all length-1 candidates, then all length-2, and so on; total = sum over L = 1..MAX_LEN of (max-min+1)^L.

Reset
REQ-027 While reset is high, all outputs SHALL take their reset values on every clock edge: length = 1, char0 = min, count = 0, exhausted = 0.
REQ-028 In the same reset, the state SHALL become RUN with valid = 0 and rangeError = 0; if the captured min > max it SHALL become ERROR with rangeError = 1.
REQ-029 During reset, chunk SHALL already encode the first candidate; valid SHALL rise on the first edge with reset low (RUN only).
REQ-030 Reset asserted mid-run or in DONE SHALL discard all progress and restart from the first candidate, and SHALL take priority over a simultaneous enable.

Verification
REQ-031 min = 0x61, max = 0x7A, reset, then idle -> chunk[7:0] = 0x61, chunk[15:8] = 0x80, chunk[455:448] = 0x08, all other bits 0, length = 1, valid = 1.
REQ-032 min = 0x61, max = 0x62, MAX_LEN = 2, enable held high -> candidates in order "a", "b", "aa", "ba", "ab", "bb"; then valid = 0, exhausted = 1, count = 6, chunk still encodes "bb".
REQ-033 min = 0x61, max = 0x7A, 26 consumes -> length = 2, chunk[15:0] = 0x6161, chunk[23:16] = 0x80, chunk[455:448] = 0x10.
REQ-034 enable toggling 1,0,1,0 from reset -> only 2 consumes (count = 2), candidate held on the low-enable cycles.
REQ-035 min = 0x7A, max = 0x61 at reset -> rangeError = 1, valid = 0, chunk = 0, count stays 0 under enable.
REQ-036 Reset pulsed after 100 consumes while enable is high -> count = 0, length = 1, char0 = min, valid = 1 the cycle after reset falls.
